// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: result kinds, EX forward-select codes and the
// shadow-entry record used by the hazard/forwarding logic.
package pipe_pkg;

    localparam int SH_REG_W = 5;

    typedef logic [1:0] kind_t;

    localparam kind_t KIND_NONE = 2'd0;
    localparam kind_t KIND_ALU  = 2'd1;
    localparam kind_t KIND_IMM  = 2'd2;
    localparam kind_t KIND_LOAD = 2'd3;

    // Codes must match the operand mux ordering in the EX stage.
    localparam logic [2:0] FWD_RF      = 3'd0;
    localparam logic [2:0] FWD_IMM_MEM = 3'd1;
    localparam logic [2:0] FWD_ALU_MEM = 3'd2;
    localparam logic [2:0] FWD_IMM_WB  = 3'd3;
    localparam logic [2:0] FWD_ALU_WB  = 3'd4;
    localparam logic [2:0] FWD_MEM_WB  = 3'd5;

    typedef struct packed {
        logic                v;
        logic [SH_REG_W-1:0] dst;
        kind_t               kind;
    } shadow_t;

    // True when the entry will write register r (r0 is never written).
    function automatic logic writes_reg(shadow_t e, logic [SH_REG_W-1:0] r);
        return e.v && (e.kind != KIND_NONE) && (e.dst != '0) && (e.dst == r);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forward-select logic: picks the youngest in-flight producer of
// the source register, as seen from ID one cycle before the operand reaches EX.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_W = SH_REG_W,
    parameter int FWD_W = 3
) (
    input  logic             use_src,
    input  logic [REG_W-1:0] src,
    input  shadow_t          ex_e,
    input  shadow_t          mem_e,
    output logic [FWD_W-1:0] sel
);

    // ex_e is checked first so the youngest producer wins; a load in ex_e is
    // the stall case and leaves the select at the register file.
    always_comb begin
        sel = FWD_W'(FWD_RF);
        if (use_src && (src != '0)) begin
            if (writes_reg(ex_e, src)) begin
                case (ex_e.kind)
                    KIND_ALU: sel = FWD_W'(FWD_ALU_MEM);
                    KIND_IMM: sel = FWD_W'(FWD_IMM_MEM);
                    default:  sel = FWD_W'(FWD_RF);
                endcase
            end else if (writes_reg(mem_e, src)) begin
                case (mem_e.kind)
                    KIND_ALU:  sel = FWD_W'(FWD_ALU_WB);
                    KIND_IMM:  sel = FWD_W'(FWD_IMM_WB);
                    KIND_LOAD: sel = FWD_W'(FWD_MEM_WB);
                    default:   sel = FWD_W'(FWD_RF);
                endcase
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit for the 5-stage pipeline.
// Optional stall_cnt output is enabled by defining FWD_HAZARD_STALL_CNT_EN.
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = SH_REG_W,
    parameter int FWD_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic [1:0]       id_kind,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [FWD_W-1:0] ALUa_Fwd_ctr,
    output logic [FWD_W-1:0] ALUb_Fwd_ctr
`ifdef FWD_HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    shadow_t ex_e;
    shadow_t mem_e;
    shadow_t wb_e;

    logic [FWD_W-1:0] sel_a;
    logic [FWD_W-1:0] sel_b;
    logic             ex_hit;

    fwd_sel #(.REG_W(REG_W), .FWD_W(FWD_W)) u_sel_a (
        .use_src (id_use_rs),
        .src     (id_rs),
        .ex_e    (ex_e),
        .mem_e   (mem_e),
        .sel     (sel_a)
    );

    fwd_sel #(.REG_W(REG_W), .FWD_W(FWD_W)) u_sel_b (
        .use_src (id_use_rt),
        .src     (id_rt),
        .ex_e    (ex_e),
        .mem_e   (mem_e),
        .sel     (sel_b)
    );

    // A flush squashes the ID instruction, so it can never also be stalled.
    always_comb begin
        ex_hit = (id_use_rs && writes_reg(ex_e, id_rs)) ||
                 (id_use_rt && writes_reg(ex_e, id_rt));
        stall  = id_valid && !flush && (ex_e.kind == KIND_LOAD) && ex_hit;
        bubble = stall || flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_e         <= '0;
            mem_e        <= '0;
            wb_e         <= '0;
            ALUa_Fwd_ctr <= '0;
            ALUb_Fwd_ctr <= '0;
        end else begin
            wb_e  <= mem_e;
            mem_e <= ex_e;
            if (bubble) begin
                ex_e         <= '0;
                ALUa_Fwd_ctr <= '0;
                ALUb_Fwd_ctr <= '0;
            end else begin
                ex_e         <= '{v: id_valid, dst: id_dst, kind: id_kind};
                ALUa_Fwd_ctr <= sel_a;
                ALUb_Fwd_ctr <= sel_b;
            end
        end
    end

`ifdef FWD_HAZARD_STALL_CNT_EN
    // Wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    // wb_e only feeds the optional counter and debug probes.
    logic unused_wb;
    assign unused_wb = ^wb_e;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: table-driven instruction stream with
// a queue of expected selects, plus a repeated load-use sequence.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_dst;
    logic [1:0] id_kind;
    logic       flush;
    logic       stall;
    logic       bubble;
    logic [2:0] ALUa_Fwd_ctr;
    logic [2:0] ALUb_Fwd_ctr;
`ifdef FWD_HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    fwd_hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_dst       (id_dst),
        .id_kind      (id_kind),
        .flush        (flush),
        .stall        (stall),
        .bubble       (bubble),
        .ALUa_Fwd_ctr (ALUa_Fwd_ctr),
        .ALUb_Fwd_ctr (ALUb_Fwd_ctr)
`ifdef FWD_HAZARD_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] dst;
        logic [1:0] kind;
        logic       flush;
        logic       rst;
        logic       exp_stall;
        logic       exp_bubble;
        logic [2:0] exp_a;
        logic [2:0] exp_b;
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] a;
        logic [2:0] b;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(string name, logic valid, logic [4:0] rs, logic [4:0] rt,
                                logic use_rs, logic use_rt, logic [4:0] dst, logic [1:0] kind,
                                logic fl, logic rs_t, logic st, logic bub,
                                logic [2:0] a, logic [2:0] b);
        vec_t v;
        v.name = name; v.valid = valid; v.rs = rs; v.rt = rt;
        v.use_rs = use_rs; v.use_rt = use_rt; v.dst = dst; v.kind = kind;
        v.flush = fl; v.rst = rs_t; v.exp_stall = st; v.exp_bubble = bub;
        v.exp_a = a; v.exp_b = b;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one ID instruction, check the combinational controls, queue the selects.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst       = v.rst;
        id_valid  = v.valid;
        id_rs     = v.rs;
        id_rt     = v.rt;
        id_use_rs = v.use_rs;
        id_use_rt = v.use_rt;
        id_dst    = v.dst;
        id_kind   = v.kind;
        flush     = v.flush;
        #1;
        checkOutput({v.name, ".stall"}, {31'd0, stall}, {31'd0, v.exp_stall});
        checkOutput({v.name, ".bubble"}, {31'd0, bubble}, {31'd0, v.exp_bubble});
        e.name = v.name;
        e.a    = v.exp_a;
        e.b    = v.exp_b;
        sb.push_back(e);
    endtask

    // Advance one clock and compare the registered selects against the queue.
    task automatic stepAndCompare();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard: empty queue, got a=%0d b=%0d", ALUa_Fwd_ctr, ALUb_Fwd_ctr);
        end else begin
            e = sb.pop_front();
            checkOutput({e.name, ".selA"}, {29'd0, ALUa_Fwd_ctr}, {29'd0, e.a});
            checkOutput({e.name, ".selB"}, {29'd0, ALUb_Fwd_ctr}, {29'd0, e.b});
        end
    endtask

    task automatic resetDut();
        rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_dst = '0; id_kind = 2'd0; flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        resetDut();
        #1;
        checkOutput("reset.stall", {31'd0, stall}, 32'd0);
        checkOutput("reset.bubble", {31'd0, bubble}, 32'd0);
        checkOutput("reset.selA", {29'd0, ALUa_Fwd_ctr}, 32'd0);
        checkOutput("reset.selB", {29'd0, ALUb_Fwd_ctr}, 32'd0);
`ifdef FWD_HAZARD_STALL_CNT_EN
        checkOutput("reset.stall_cnt", stall_cnt, 32'd0);
`endif

        //                name          vld rs  rt  urs urt dst kind flsh rst  st bub a  b
        vecs.push_back(mk("add_r3",     1, 1,  2,  1,  1,  3,  1,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("sub_use_r3", 1, 3,  4,  1,  1,  6,  1,  0,  0,   0, 0, 2, 0));
        vecs.push_back(mk("lui_r5",     1, 0,  0,  0,  0,  5,  2,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("indep_r8",   1, 1,  2,  1,  1,  8,  1,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("rd_rt_r5",   1, 1,  5,  1,  1,  9,  1,  0,  0,   0, 0, 0, 3));
        vecs.push_back(mk("lw_r4",      1, 1,  0,  1,  0,  4,  3,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("add_r4_stl", 1, 4,  2,  1,  1, 10,  1,  0,  0,   1, 1, 0, 0));
        vecs.push_back(mk("add_r4_go",  1, 4,  2,  1,  1, 10,  1,  0,  0,   0, 0, 5, 0));
        vecs.push_back(mk("alu_r7",     1, 1,  2,  1,  1,  7,  1,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("imm_r7",     1, 0,  0,  0,  0,  7,  2,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("rd_r7_young",1, 7,  7,  1,  1, 11,  1,  0,  0,   0, 0, 1, 1));
        vecs.push_back(mk("rd_r7_mem",  1, 7,  7,  1,  0, 12,  1,  0,  0,   0, 0, 3, 0));
        vecs.push_back(mk("alu_dst0",   1, 1,  2,  1,  1,  0,  1,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("rd_r0",      1, 0,  0,  1,  1, 13,  1,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("lw_r4_b",    1, 1,  0,  1,  0,  4,  3,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("flush_lu",   1, 4,  4,  1,  1, 14,  1,  1,  0,   0, 1, 0, 0));
        vecs.push_back(mk("after_flush",1, 14, 3,  1,  1, 15,  1,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("lw_r4_c",    1, 1,  0,  1,  0,  4,  3,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("rst_in_stl", 1, 4,  4,  1,  1, 16,  1,  0,  1,   1, 1, 0, 0));
        vecs.push_back(mk("after_rst",  1, 4,  4,  1,  1, 16,  1,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("idle_a",     0, 0,  0,  0,  0,  0,  0,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("alu_r20",    1, 1,  2,  1,  1, 20,  1,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("idle_b",     0, 0,  0,  0,  0,  0,  0,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("rd_r20_wb",  1, 20, 20, 1,  1, 22,  1,  0,  0,   0, 0, 4, 4));
        vecs.push_back(mk("alu_r21",    1, 1,  2,  1,  1, 21,  1,  0,  0,   0, 0, 0, 0));
        vecs.push_back(mk("rd_rt_r21",  1, 21, 21, 0,  1, 23,  1,  0,  0,   0, 0, 0, 2));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            stepAndCompare();
        end

        // Three back-to-back load-use pairs: each stalls exactly once, then forwards from WB.
        resetDut();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mk("pair_lw",   1, 1, 0, 1, 0,  4, 3, 0, 0, 0, 0, 0, 0));
            stepAndCompare();
            applyStimulus(mk("pair_stl",  1, 4, 2, 1, 1, 10, 1, 0, 0, 1, 1, 0, 0));
            stepAndCompare();
            applyStimulus(mk("pair_go",   1, 4, 2, 1, 1, 10, 1, 0, 0, 0, 0, 5, 0));
            stepAndCompare();
        end
`ifdef FWD_HAZARD_STALL_CNT_EN
        checkOutput("stall_cnt_3", stall_cnt, 32'd3);
`endif

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Produces the forwarding selects consumed by the EX stage operand muxes, plus load-use stall and bubble controls for the 5-stage pipeline.
- Keeps a shadow pipeline of destination registers and result kinds for the EX, MEM and WB slots, so the ID/EX register only carries selects, not raw tags.
- Evaluates the instruction in ID each cycle and registers its select codes, so the codes arrive at EX together with that instruction.

Parameters:
- REG_W, 5, register-index width.
- FWD_W, 3, forward-select width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_rs  in  REG_W  ID source A index
- id_rt  in  REG_W  ID source B index
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt (as a register operand)
- id_dst  in  REG_W  ID destination index
- id_kind  in  2  result kind: 0 NONE, 1 ALU, 2 IMM (ExtImm result), 3 LOAD
- flush  in  1  taken branch/jump resolved in EX; squash the ID instruction
- stall  out  1  hold PC and IF/ID (combinational)
- bubble  out  1  load NOP into ID/EX (combinational)
- ALUa_Fwd_ctr  out  FWD_W  registered select for EX operand A
- ALUb_Fwd_ctr  out  FWD_W  registered select for EX operand B

Behaviour:
- Select encoding is fixed and must match the EX muxes:
  - 0 = register file
  - 1 = ExtImm_MEM
  - 2 = ALUres_MEM
  - 3 = ExtImm_WB
  - 4 = ALUres_WB
  - 5 = MemRd_WB
  - 6 and 7 are never driven.
- Shadow entries ex_e, mem_e and wb_e each hold {v, dst, kind}. An entry is "writing" when v=1, kind!=NONE and dst!=0.
- Load-use hazard:
  - stall = id_valid & !flush & ex_e writing & ex_e.kind==LOAD & ((id_use_rs & id_rs==ex_e.dst) | (id_use_rt & id_rt==ex_e.dst)).
  - bubble = stall | flush.
- Select computation, per operand, with X = rs/use_rs for A and rt/use_rt for B:
  - If use=0 or X==0: select 0.
  - Else if ex_e writes X (it will be in MEM next cycle): ALU gives 2, IMM gives 1. A LOAD match here is the stall case and yields 0.
  - Else if mem_e writes X (it will be in WB next cycle): ALU gives 4, IMM gives 3, LOAD gives 5.
  - Else: select 0.
  - The youngest producer wins.
- Updates on each rising edge:
  - wb_e <= mem_e; mem_e <= ex_e.
  - ex_e <= {id_valid, id_dst, id_kind} if bubble=0, else all zero.
  - The ALUx_Fwd_ctr registers take the computed selects when bubble=0; when bubble=1 they take 0.
- wb_e is kept for the optional counter and debug only. Same-cycle write-back to an ID read is handled by the write-through register file, so this block never forwards from wb_e.
- flush and stall together: flush wins and stall is forced to 0.
- Latency:
  - stall and bubble are combinational from the ID inputs in the same cycle.
  - Selects become valid one cycle after ID evaluation, aligned with EX.
- A stall lasts exactly one cycle per load-use pair, because the load moves on to MEM.
- Reset: all shadow entries are zero and both selects are 0. stall and bubble are 0 while no entry is writing. Reset applied mid-stall clears the stall on the next cycle.

Optional Feature:
- Macro: FWD_HAZARD_STALL_CNT_EN.
- When defined, the block adds an output stall_cnt (32 bits).
  - Clears on reset.
  - Increments on every cycle with stall=1 and wraps at 2^32.
- When the macro is undefined, the port and the counter are absent.

Decomposition:
- Shared package pipe_pkg holds:
  - kind constants KIND_NONE, KIND_ALU, KIND_IMM, KIND_LOAD
  - FWD_RF, FWD_IMM_MEM, FWD_ALU_MEM, FWD_IMM_WB, FWD_ALU_WB, FWD_MEM_WB
  - the shadow-entry struct
- One sub-module, fwd_sel: combinational per-operand select logic, instantiated twice (A and B).

Test Plan:
- ALU producer then consumer: add r3 followed by sub using rs=r3 -> on the next cycle ALUa_Fwd_ctr=2, stall=0.
- Producer two ahead: lui-type IMM to r5, an independent instruction, then a reader of rt=r5 -> ALUb_Fwd_ctr=3.
- Load-use: lw r4 followed by add with rs=r4 -> stall=1 and bubble=1 for exactly one cycle, then ALUa_Fwd_ctr=5, with the add held in ID.
- Double producer: ALU to r7, then IMM to r7, then a reader of r7 -> select 1 (youngest wins, not 4).
- Register zero and flush:
  - Producer with dst=0 and reader rs=0 -> select 0.
  - flush asserted together with a load-use condition -> stall=0, bubble=1, and the next selects are 0.
- Reset during a stall -> all outputs 0 on the next cycle. With FWD_HAZARD_STALL_CNT_EN defined, stall_cnt counts 3 after three load-use pairs.
